// File: rtl/gpio_pkg.sv
// Shared widths, defaults and debounce FSM state type for the GPIO input conditioner.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH       = 16;
  localparam int unsigned DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned CNT_W            = 16;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pad bit: 2-flop synchronizer, stability-count debounce FSM and registered edge pulses.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_q1;
  logic             sync_q2;
  deb_state_e       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pin;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has disagreed with the current one long enough.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE: begin
          if (sync_q2 != level) begin
            state <= COUNTING;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        COUNTING: begin
          if (sync_q2 == level) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            level <= sync_q2;
            rise  <= sync_q2;
            fall  <= ~sync_q2;
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Debounces WIDTH raw pads into stable levels, edge pulses, sticky event flags and an IRQ.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = GPIO_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [WIDTH-1:0] PINS,
  input  logic [WIDTH-1:0] EVENT_CLR,
  output logic [WIDTH-1:0] GPIOIN,
  output logic [WIDTH-1:0] EDGE_RISE,
  output logic [WIDTH-1:0] EDGE_FALL,
  output logic [WIDTH-1:0] EVENT,
  output logic             IRQ
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .pin   (PINS[i]),
      .level (GPIOIN[i]),
      .rise  (EDGE_RISE[i]),
      .fall  (EDGE_FALL[i])
    );
  end

  // Sticky flags; a new edge beats a simultaneous clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      EVENT <= '0;
    end else begin
      EVENT <= (EVENT & ~EVENT_CLR) | EDGE_RISE | EDGE_FALL;
    end
  end

  assign IRQ = |EVENT;

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of input pins conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a level; legal range 1..65535.
REQ-003 SHALL have port HCLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PINS  input  WIDTH  raw asynchronous pad inputs, e.g. switches and buttons.
REQ-006 SHALL have port EVENT_CLR  input  WIDTH  per-bit single-cycle clear of the sticky event flags.
REQ-007 SHALL have port GPIOIN  output  WIDTH  debounced stable levels; drives the GPIO subordinate's GPIOIN port directly.
REQ-008 SHALL have port EDGE_RISE  output  WIDTH  one-cycle pulse per bit when its debounced level goes 0->1.
REQ-009 SHALL have port EDGE_FALL  output  WIDTH  one-cycle pulse per bit when its debounced level goes 1->0.
REQ-010 SHALL have port EVENT  output  WIDTH  sticky per-bit flag, set by any debounced edge.
REQ-011 SHALL have port IRQ  output  1  OR-reduction of EVENT.

Function
REQ-012 Each PINS bit SHALL pass through a 2-flop synchronizer; only the second-stage value (sync) is used downstream.
REQ-013 Each bit SHALL run an independent FSM with states STABLE and COUNTING and a 16-bit counter.
REQ-014 STABLE: when sync != GPIOIN[i], go to COUNTING with counter=1; otherwise hold, with counter=0.
REQ-015 COUNTING: when sync == GPIOIN[i], return to STABLE with counter=0, GPIOIN unchanged (glitch rejected).
REQ-016 COUNTING: when sync != GPIOIN[i] and counter == DEBOUNCE_CYCLES, GPIOIN[i] takes sync, the matching edge pulse asserts for exactly that one cycle, and the FSM goes to STABLE with counter=0.
REQ-017 COUNTING: otherwise counter increments by 1. The counter never exceeds DEBOUNCE_CYCLES and never wraps.
REQ-018 Latency SHALL be: a pad change held steady is reflected on GPIOIN exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the first HCLK edge that samples it.
REQ-019 A pulse on a pad shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on GPIOIN, EDGE_RISE, EDGE_FALL or EVENT.
REQ-020 EDGE_RISE[i] and EDGE_FALL[i] SHALL never be high in the same cycle. Edge outputs are registered.
REQ-021 EVENT[i] SHALL set on the cycle after EDGE_RISE[i] or EDGE_FALL[i], and clear on the cycle after EVENT_CLR[i].
REQ-022 If a set and EVENT_CLR[i] occur in the same cycle, set SHALL win.
REQ-023 IRQ SHALL be combinational OR of the registered EVENT bits, with no added latency.
REQ-024 With DEBOUNCE_CYCLES=1, a single cycle of disagreement in COUNTING SHALL be enough to accept the new level.

Reset
REQ-025 While HRESET is high: synchronizer flops, GPIOIN, EDGE_RISE, EDGE_FALL, EVENT, all counters and IRQ SHALL be 0, and all FSMs SHALL be in STABLE.
REQ-026 Asserting HRESET mid-count SHALL abandon the count with no edge pulse.
REQ-027 After release, a pad held at 1 SHALL produce one EDGE_RISE per bit after the REQ-018 latency.

Structure
REQ-028 Package gpio_pkg SHALL hold: GPIO_WIDTH=16, DEBOUNCE_DEFAULT=50000, CNT_W=16, and the FSM state enum {STABLE, COUNTING}.
REQ-029 The per-bit synchronizer, FSM, counter and edge logic SHALL live in sub-module gpio_debounce_bit, instantiated WIDTH times by a generate loop.
REQ-030 EVENT and IRQ logic SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, then PINS=16'h0001 held: GPIOIN=16'h0001 exactly 7 cycles after first sample; EDGE_RISE=16'h0001 for one cycle; EVENT[0]=1 and IRQ=1 on the next cycle.
REQ-032 PINS[3] high for 3 cycles, then low: GPIOIN, EDGE_RISE, EDGE_FALL and EVENT remain 0.
REQ-033 PINS[5] bounces 1,0,1,1,1,1,1: count restarts at the bounce; GPIOIN[5] rises 7 cycles after the final 0->1; exactly one EDGE_RISE.
REQ-034 Same-cycle EDGE_FALL[2] and EVENT_CLR[2]=1: EVENT[2] stays 1. EVENT_CLR[2]=1 alone on the next cycle: EVENT[2]=0, IRQ=0.
REQ-035 HRESET asserted while bit 7 is at counter=3: no EDGE_RISE; all outputs are 0 during reset; after release with the pad still high, bit 7 rises after the full 7-cycle latency.
REQ-036 PINS=16'hFFFF from reset: all 16 bits rise together; EDGE_RISE=16'hFFFF for one cycle; EDGE_FALL stays 0.
